uart_host_link: RTL and testbench



---
 rtl/uart_host_link_pkg.sv | 19 +
 rtl/uart_port.sv | 111 +++++++++++
 rtl/uart_host_link.sv | 157 +++++++++++++++
 tb/tb_uart_host_link.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_link_pkg.sv
// rtl/uart_host_link_pkg.sv - shared op codes, frame lengths and host FSM states
package uart_host_link_pkg;

   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   localparam int WRITE_BYTES = 3;
   localparam int READ_BYTES  = 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT_TX,
      WAIT_RX,
      DONE
   } state_t;

endpackage

// File: rtl/uart_port.sv
// rtl/uart_port.sv - 8N1 UART transmitter/receiver with send/receive handshake
module uart_port #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int DATA_LEN     = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                send_sig,
   input  logic [DATA_LEN-1:0] data_out,
   output logic                tx_busy,
   output logic                tx_done,
   output logic                u_tx_data,
   input  logic                u_rx_data,
   output logic                receive_sig,
   output logic [DATA_LEN-1:0] data_in
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_LEN + 2);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_LEN + 1);

   logic [DATA_LEN+1:0] tx_shift;
   logic [CW-1:0]       tx_clk_cnt;
   logic [BW-1:0]       tx_bit_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
         u_tx_data  <= 1'b1;
         tx_shift   <= '1;
         tx_clk_cnt <= '0;
         tx_bit_cnt <= '0;
      end else begin
         tx_done <= 1'b0;
         if (!tx_busy) begin
            if (send_sig) begin
               tx_busy    <= 1'b1;
               tx_shift   <= {1'b1, data_out, 1'b0};
               u_tx_data  <= 1'b0;
               tx_clk_cnt <= '0;
               tx_bit_cnt <= '0;
            end
         end else if (tx_clk_cnt != BIT_END) begin
            tx_clk_cnt <= tx_clk_cnt + 1'b1;
         end else begin
            tx_clk_cnt <= '0;
            if (tx_bit_cnt == LAST_BIT) begin
               tx_busy   <= 1'b0;
               tx_done   <= 1'b1;
               u_tx_data <= 1'b1;
            end else begin
               tx_bit_cnt <= tx_bit_cnt + 1'b1;
               tx_shift   <= {1'b1, tx_shift[DATA_LEN+1:1]};
               u_tx_data  <= tx_shift[1];
            end
         end
      end
   end

   logic                rx_meta;
   logic                rx_sync;
   logic                rx_active;
   logic [CW-1:0]       rx_clk_cnt;
   logic [BW-1:0]       rx_bit_cnt;
   logic [DATA_LEN-1:0] rx_shift;

   // Samples at mid-bit; a start bit that is high again at its centre is treated as a glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta     <= 1'b1;
         rx_sync     <= 1'b1;
         rx_active   <= 1'b0;
         rx_clk_cnt  <= '0;
         rx_bit_cnt  <= '0;
         rx_shift    <= '0;
         receive_sig <= 1'b0;
         data_in     <= '0;
      end else begin
         rx_meta     <= u_rx_data;
         rx_sync     <= rx_meta;
         receive_sig <= 1'b0;
         if (!rx_active) begin
            if (!rx_sync) begin
               rx_active  <= 1'b1;
               rx_clk_cnt <= HALF;
               rx_bit_cnt <= '0;
            end
         end else if (rx_clk_cnt != '0) begin
            rx_clk_cnt <= rx_clk_cnt - 1'b1;
         end else begin
            rx_clk_cnt <= BIT_END;
            rx_bit_cnt <= rx_bit_cnt + 1'b1;
            if (rx_bit_cnt == '0) begin
               if (rx_sync) rx_active <= 1'b0;
            end else if (rx_bit_cnt == LAST_BIT) begin
               rx_active <= 1'b0;
               if (rx_sync) begin
                  receive_sig <= 1'b1;
                  data_in     <= rx_shift;
               end
            end else begin
               rx_shift <= {rx_sync, rx_shift[DATA_LEN-1:1]};
            end
         end
      end
   end

endmodule

// File: rtl/uart_host_link.sv
// rtl/uart_host_link.sv - serialises a bus request into bridge command bytes and awaits read data
module uart_host_link
   import uart_host_link_pkg::*;
#(
   parameter int SLAVE_LEN    = 2,
   parameter int ADDR_LEN     = 12,
   parameter int DATA_LEN     = 8,
   parameter int CLKS_PER_BIT = 2604,
   parameter int MAX_COUNT    = 50000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [SLAVE_LEN-1:0] req_slave,
   input  logic [ADDR_LEN-1:0]  req_addr,
   input  logic [DATA_LEN-1:0]  req_wdata,
   output logic                 rsp_valid,
   output logic [DATA_LEN-1:0]  rsp_rdata,
   output logic                 rsp_timeout,
   input  logic                 u_rx_data,
   output logic                 u_tx_data
);

   localparam int CNT_W = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);

   state_t state, next_state;

   logic                 lat_write;
   logic [SLAVE_LEN-1:0] lat_slave;
   logic [ADDR_LEN-1:0]  lat_addr;
   logic [DATA_LEN-1:0]  lat_wdata;
   logic [1:0]           byte_idx;
   logic [DATA_LEN-1:0]  tx_byte;
   logic [DATA_LEN-1:0]  frame_byte;
   logic [CNT_W-1:0]     to_cnt;

   logic                 send_sig;
   logic                 tx_busy;
   logic                 tx_done;
   logic                 receive_sig;
   logic [DATA_LEN-1:0]  data_in;

   logic [1:0] num_bytes;
   logic       last_byte;
   logic       terminal;

   assign num_bytes = lat_write ? 2'(WRITE_BYTES) : 2'(READ_BYTES);
   assign last_byte = (byte_idx + 2'd1) == num_bytes;
   assign terminal  = (to_cnt == CNT_LAST);

   always_comb begin
      case (byte_idx)
         2'd0:    frame_byte = {(lat_write ? OP_WRITE : OP_READ), lat_slave, lat_addr[11:8]};
         2'd1:    frame_byte = lat_addr[7:0];
         default: frame_byte = lat_wdata;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req_valid) next_state = LOAD;
         LOAD:    next_state = SEND;
         SEND:    if (!tx_busy) next_state = WAIT_TX;
         WAIT_TX: begin
            if (tx_done) begin
               if (!last_byte)     next_state = LOAD;
               else if (lat_write) next_state = DONE;
               else                next_state = WAIT_RX;
            end
         end
         // A byte landing on the terminal count still completes the read.
         WAIT_RX: if (receive_sig || terminal) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == DONE);
      send_sig  = (state == SEND) && !tx_busy;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_write   <= 1'b0;
         lat_slave   <= '0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         byte_idx    <= '0;
         tx_byte     <= '0;
         to_cnt      <= '0;
         rsp_rdata   <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               byte_idx <= '0;
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_slave <= req_slave;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
               end
            end
            LOAD: tx_byte <= frame_byte;
            WAIT_TX: begin
               if (tx_done) begin
                  byte_idx <= byte_idx + 2'd1;
                  to_cnt   <= '0;
                  if (last_byte && lat_write) begin
                     rsp_rdata   <= '0;
                     rsp_timeout <= 1'b0;
                  end
               end
            end
            WAIT_RX: begin
               if (!terminal) to_cnt <= to_cnt + 1'b1;
               if (receive_sig) begin
                  rsp_rdata   <= data_in;
                  rsp_timeout <= 1'b0;
               end else if (terminal) begin
                  rsp_rdata   <= '0;
                  rsp_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   uart_port #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .DATA_LEN    (DATA_LEN)
   ) u_port (
      .clk        (clk),
      .reset      (reset),
      .send_sig   (send_sig),
      .data_out   (tx_byte),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .u_tx_data  (u_tx_data),
      .u_rx_data  (u_rx_data),
      .receive_sig(receive_sig),
      .data_in    (data_in)
   );

endmodule

// File: tb/tb_uart_host_link.sv
// tb/tb_uart_host_link.sv - randomized and directed bench with a bridge-side UART model
module tb_uart_host_link;

   localparam int CPB    = 4;
   localparam int MAXC   = 200;
   // Reply start bit to byte-received: centre of the stop bit plus synchroniser and start detect.
   localparam int RX_LAT = 9 * CPB + CPB / 2 + 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_slave = '0;
   logic [11:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic        req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_timeout;
   logic        u_rx_data;
   logic        u_tx_data;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   uart_host_link #(
      .SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .CLKS_PER_BIT(CPB), .MAX_COUNT(MAXC)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_slave(req_slave), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .u_rx_data(u_rx_data), .u_tx_data(u_tx_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed cycle %0d, required finish before that", cyc);
      $fatal(1, "watchdog");
   end

   // Bridge receive side: decode 8N1 frames off u_tx_data, noting when each frame ends.
   logic [7:0] cap_q[$];
   logic       stop_q[$];
   int         end_q[$];
   bit         dec_busy = 1'b0;
   int         dec_start = 0;
   logic [7:0] dec_sh = '0;

   always @(negedge clk) begin
      if (reset) begin
         dec_busy <= 1'b0;
      end else if (!dec_busy) begin
         if (u_tx_data == 1'b0) begin
            dec_busy  <= 1'b1;
            dec_start <= cyc;
         end
      end else begin
         for (int k = 1; k <= 8; k++)
            if (cyc - dec_start == k * CPB + CPB / 2) dec_sh[k-1] <= u_tx_data;
         if (cyc - dec_start == 9 * CPB + CPB / 2) begin
            cap_q.push_back(dec_sh);
            stop_q.push_back(u_tx_data);
            end_q.push_back(dec_start + 10 * CPB);
            dec_busy <= 1'b0;
         end
      end
   end

   // Bridge transmit side: sends reply_byte starting at cycle reply_at once armed.
   bit         reply_armed = 1'b0;
   bit         reply_busy = 1'b0;
   int         reply_at = 0;
   int         reply_start = 0;
   logic [7:0] reply_byte = '0;
   logic [9:0] rframe;

   initial begin
      u_rx_data = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (reply_armed && cyc >= reply_at) begin
            reply_busy  = 1'b1;
            reply_armed = 1'b0;
            reply_start = cyc;
            rframe      = {1'b1, reply_byte, 1'b0};
            for (int k = 0; k < 10; k++) begin
               u_rx_data = rframe[k];
               repeat (CPB) @(posedge clk);
               #1;
            end
            reply_busy = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input bit wr, input logic [1:0] sl, input logic [11:0] ad, input logic [7:0] wd);
      int k = 0;
      while (!req_ready && k < 2000) begin @(negedge clk); k++; end
      check("ready_before_req", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = wr; req_slave = sl; req_addr = ad; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = 1'($urandom); req_slave = 2'($urandom);
      req_addr = 12'($urandom); req_wdata = 8'($urandom);
      check("ready_drop", req_ready, 0);
   endtask

   task automatic run_txn(input string tag, input bit wr, input logic [1:0] sl, input logic [11:0] ad,
                          input logic [7:0] wd, input bit reply, input int d, input logic [7:0] rb);
      logic [7:0] exp_b[3];
      logic [7:0] exp_rd;
      logic       exp_to;
      int n, k, t_end, got_cyc, exp_cyc;
      bit seen;
      exp_b[0] = {(wr ? 2'b01 : 2'b10), sl, ad[11:8]};
      exp_b[1] = ad[7:0];
      exp_b[2] = wd;
      n = wr ? 3 : 2;
      cap_q.delete(); stop_q.delete(); end_q.delete();
      issue(wr, sl, ad, wd);
      k = 0;
      while (cap_q.size() < n && k < 1000) begin @(negedge clk); k++; end
      check($sformatf("%s_nbytes", tag), cap_q.size(), n);
      t_end = 0;
      for (int i = 0; i < n && i < cap_q.size(); i++) begin
         check($sformatf("%s_byte%0d", tag, i), cap_q[i], exp_b[i]);
         check($sformatf("%s_stop%0d", tag, i), stop_q[i], 1);
         t_end = end_q[i];
      end
      if (!wr && reply) begin
         reply_byte  = rb;
         reply_at    = t_end + d;
         reply_armed = 1'b1;
      end
      if (wr) begin
         exp_cyc = t_end + 1; exp_rd = 8'h00; exp_to = 1'b0;
      end else if (reply && d + RX_LAT <= MAXC) begin
         exp_cyc = t_end + d + RX_LAT + 1; exp_rd = rb; exp_to = 1'b0;
      end else begin
         exp_cyc = t_end + MAXC + 1; exp_rd = 8'h00; exp_to = 1'b1;
      end
      seen = 1'b0; k = 0; got_cyc = 0;
      while (!seen && k < MAXC + 400) begin
         @(negedge clk); k++;
         if (rsp_valid) begin seen = 1'b1; got_cyc = cyc; end
      end
      check($sformatf("%s_rsp_seen", tag), seen, 1);
      if (seen) begin
         check($sformatf("%s_rsp_cycle", tag), got_cyc, exp_cyc);
         check($sformatf("%s_rdata", tag), rsp_rdata, exp_rd);
         check($sformatf("%s_timeout", tag), rsp_timeout, exp_to);
         @(negedge clk);
         check($sformatf("%s_pulse_end", tag), rsp_valid, 0);
         check($sformatf("%s_ready_back", tag), req_ready, 1);
         check($sformatf("%s_rdata_hold", tag), rsp_rdata, exp_rd);
      end
      if (!wr && reply) begin
         k = 0;
         while ((reply_armed || reply_busy) && k < 500) begin @(negedge clk); k++; end
         check($sformatf("%s_reply_sched", tag), reply_start, reply_at);
      end
   endtask

   initial begin
      int k, pulses, lows, mode, d;
      bit wr;

      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      check("rst_tx_line", u_tx_data, 1);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_txn("write", 1'b1, 2'd2, 12'h3A5, 8'h5C, 1'b0, 0, 8'h00);
      run_txn("read", 1'b0, 2'd1, 12'h012, 8'h00, 1'b1, 30, 8'hE7);
      run_txn("read_noreply", 1'b0, 2'd0, 12'hFFF, 8'h00, 1'b0, 0, 8'h00);
      run_txn("read_tie", 1'b0, 2'd3, 12'h456, 8'h00, 1'b1, MAXC - RX_LAT, 8'hC3);
      run_txn("read_late1", 1'b0, 2'd2, 12'h800, 8'h00, 1'b1, MAXC - RX_LAT + 1, 8'h3C);

      reply_byte = 8'hFF; reply_at = cyc + 2; reply_armed = 1'b1;
      pulses = 0; k = 0;
      while ((reply_armed || reply_busy || k < 10) && k < 300) begin
         @(negedge clk); k++;
         if (rsp_valid) pulses++;
      end
      check("stray_no_rsp", pulses, 0);
      check("stray_ready", req_ready, 1);
      run_txn("stray_then_read", 1'b0, 2'd3, 12'h7C0, 8'h00, 1'b1, 25, 8'h11);

      cap_q.delete(); stop_q.delete(); end_q.delete();
      issue(1'b1, 2'd2, 12'h3A5, 8'h5C);
      k = 0;
      while (cap_q.size() < 1 && k < 1000) begin @(negedge clk); k++; end
      k = 0;
      while (u_tx_data !== 1'b0 && k < 200) begin @(negedge clk); k++; end
      check("abort_in_byte1", u_tx_data, 0);
      #2 reset = 1'b1;
      #1;
      check("abort_tx_line", u_tx_data, 1);
      check("abort_ready", req_ready, 1);
      check("abort_rsp_valid", rsp_valid, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      pulses = 0; lows = 0;
      repeat (150) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
         if (!u_tx_data) lows++;
      end
      check("abort_no_rsp", pulses, 0);
      check("abort_line_idle", lows, 0);
      run_txn("after_abort", 1'b0, 2'd1, 12'h0A5, 8'h00, 1'b1, 12, 8'h96);

      for (int i = 0; i < 14; i++) begin
         wr   = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 3);
         if (mode == 3) d = $urandom_range(MAXC - RX_LAT + 1, MAXC - RX_LAT + 20);
         else           d = $urandom_range(0, MAXC - RX_LAT);
         run_txn($sformatf("rnd%0d", i), wr, 2'($urandom), 12'($urandom), 8'($urandom),
                 mode != 0, d, 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
